msg_receive_dp: RTL

- Receiving end of the digital-modulation message link. Takes the serial stream from the message-process transmitter and recovers the parallel MSG_W-bit message.
- The transmitter holds each bit for CLKS_PER_BIT clocks, MSB first, inside a frame of FRAME_BITS bit slots.
- This block times the bit slots from a frame-start strobe and samples each message bit with a 3-sample majority vote at mid-slot.
- It presents the message with a one-cycle valid pulse at the end of the frame.

---
 rtl/msg_link_pkg.sv | 27 ++
 rtl/bit_timer.sv | 61 ++++++
 rtl/msg_receive_dp.sv | 119 +++++++++++
 3 files changed

// File: rtl/msg_link_pkg.sv
// Shared definitions for the message link: default framing, receiver FSM encoding,
// and helpers that size the bit-timing counters from the framing parameters.
package msg_link_pkg;

    localparam int CLKS_PER_BIT_DEF = 1024;
    localparam int MSG_W_DEF        = 5;
    localparam int FRAME_BITS_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } rx_state_e;

    function automatic int cyc_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    function automatic int slot_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

    localparam int CYC_W  = cyc_width(CLKS_PER_BIT_DEF);
    localparam int SLOT_W = slot_width(FRAME_BITS_DEF);

endpackage

// File: rtl/bit_timer.sv
// Bit-slot timer: clock-in-slot counter and slot counter, restartable at any time.
// Strobes flag the three mid-slot sample points; slot_end_o flags the last clock of a slot.
module bit_timer
    import msg_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    localparam int CW          = cyc_width(CLKS_PER_BIT),
    localparam int SW          = slot_width(FRAME_BITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart_i,
    input  logic          run_i,
    output logic [CW-1:0] cyc_o,
    output logic [SW-1:0] slot_o,
    output logic [2:0]    sample_strobe_o,
    output logic          slot_end_o
);

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_LO   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_HI   = CW'(CLKS_PER_BIT / 2 + 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [SW-1:0] slot_q, slot_d;

    always_comb begin
        cyc_d  = cyc_q;
        slot_d = slot_q;
        if (restart_i) begin
            // The restart cycle itself is cyc 0 of slot 0, so the register resumes at 1.
            cyc_d  = CW'(1);
            slot_d = '0;
        end else if (run_i) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d  = '0;
                slot_d = slot_q + SW'(1);
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q  <= '0;
            slot_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
        end
    end

    assign cyc_o           = cyc_q;
    assign slot_o          = slot_q;
    assign sample_strobe_o = {cyc_q == MID_HI, cyc_q == MID, cyc_q == MID_LO};
    assign slot_end_o      = (cyc_q == CYC_LAST);

endmodule

// File: rtl/msg_receive_dp.sv
// Serial message receiver: times bit slots from Start, majority-votes three mid-slot
// samples per message bit, and pulses Valid with the message FRAME_BITS*CLKS_PER_BIT clocks after Start.
module msg_receive_dp
    import msg_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int MSG_W        = MSG_W_DEF,
    parameter int FRAME_BITS   = FRAME_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             serIn,
    output logic [MSG_W-1:0] msg,
    output logic             Valid,
    output logic             Busy
);

    localparam int CW = cyc_width(CLKS_PER_BIT);
    localparam int SW = slot_width(FRAME_BITS);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_BITS - 1);
    localparam logic [SW-1:0] MSG_LAST  = SW'(MSG_W - 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cyc;
    logic [SW-1:0]    slot;
    logic [2:0]       strobe;
    logic             slot_end;
    logic [1:0]       vote_q, vote_d;
    logic [MSG_W-1:0] sr_q, sr_d, msg_q, msg_d;
    logic [MSG_W:0]   sr_ext;
    logic             in_msg, maj, last_shift;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_BITS   (FRAME_BITS)
    ) u_bit_timer (
        .clk             (clk),
        .rst             (rst),
        .restart_i       (Start),
        .run_i           (Busy),
        .cyc_o           (cyc),
        .slot_o          (slot),
        .sample_strobe_o (strobe),
        .slot_end_o      (slot_end)
    );

    // Third sample is taken live from serIn on the shift cycle.
    assign maj        = (vote_q[0] & vote_q[1]) | (vote_q[0] & serIn) | (vote_q[1] & serIn);
    assign in_msg     = (state_q == RECV) && (slot < SW'(MSG_W)) && !Start;
    assign last_shift = in_msg && strobe[2] && (slot == MSG_LAST);
    assign sr_ext     = {sr_q, maj};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Start) begin
            state_d = RECV;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RECV: begin
                    if (FRAME_BITS > MSG_W) begin
                        if (last_shift) state_d = TAIL;
                    end else if (slot == SLOT_LAST && slot_end) begin
                        state_d = DONE;
                    end
                end
                TAIL: if (slot == SLOT_LAST && cyc == CYC_LAST) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        Valid = (state_q == DONE);
        Busy  = (state_q == RECV) || (state_q == TAIL);
    end

    always_comb begin
        vote_d = vote_q;
        sr_d   = sr_q;
        msg_d  = msg_q;
        if (Start) begin
            vote_d = '0;
            sr_d   = '0;
        end else if (in_msg) begin
            if (strobe[0]) vote_d[0] = serIn;
            if (strobe[1]) vote_d[1] = serIn;
            if (strobe[2]) sr_d      = sr_ext[MSG_W-1:0];
        end
        // Load on entry so msg changes in the same cycle Valid is high.
        if (state_d == DONE) msg_d = sr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vote_q <= '0;
            sr_q   <= '0;
            msg_q  <= '0;
        end else begin
            vote_q <= vote_d;
            sr_q   <= sr_d;
            msg_q  <= msg_d;
        end
    end

    assign msg = msg_q;

endmodule
